// File: rtl/cache_block_transfer_buffer_pkg.sv
// Shared types and sizing constants for the cache block-transfer buffer.
// The FSM state encoding and the default block geometry live here.
package cache_block_transfer_buffer_pkg;

  localparam int BW_BLOCK_DEF    = 2;
  localparam int WORDS_PER_BLOCK = 1 << BW_BLOCK_DEF;
  localparam int CNT_W           = BW_BLOCK_DEF + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_FILL,
    ST_WB_ISSUE,
    ST_WB_SEND,
    ST_RD_ISSUE,
    ST_RD_FILL
  } state_t;

  function automatic int words_per_block(input int bw_block);
    return 1 << bw_block;
  endfunction

endpackage

// File: rtl/cache_block_transfer_buffer_if.sv
// Cache-side handshake and memory-side burst signals of the transfer buffer.
// slave is the buffer's view; master is the view of the surrounding cache/memory.
interface cache_block_transfer_buffer_if #(
  parameter int BW_ADDR = 24
);
  import cache_block_transfer_buffer_pkg::*;

  logic               cache_req_i;
  logic               cache_rw_i;
  logic [BW_ADDR-1:0] cache_add_i;
  logic               cache_write_i;
  logic [31:0]        cache_data_i;
  logic               cache_read_i;
  logic               cache_ready_req_o;
  logic               cache_ready_write_o;
  logic               cache_ready_read_o;
  logic [31:0]        cache_data_o;
  logic               mem_req_o;
  logic               mem_rw_o;
  logic [BW_ADDR-1:0] mem_add_o;
  logic               mem_ready_i;
  logic               mem_valid_o;
  logic [31:0]        mem_data_o;
  logic               mem_valid_i;
  logic [31:0]        mem_data_i;
  logic               err_o;

  modport slave (
    input  cache_req_i, cache_rw_i, cache_add_i, cache_write_i, cache_data_i,
           cache_read_i, mem_ready_i, mem_valid_i, mem_data_i,
    output cache_ready_req_o, cache_ready_write_o, cache_ready_read_o, cache_data_o,
           mem_req_o, mem_rw_o, mem_add_o, mem_valid_o, mem_data_o, err_o
  );

  modport master (
    output cache_req_i, cache_rw_i, cache_add_i, cache_write_i, cache_data_i,
           cache_read_i, mem_ready_i, mem_valid_i, mem_data_i,
    input  cache_ready_req_o, cache_ready_write_o, cache_ready_read_o, cache_data_o,
           mem_req_o, mem_rw_o, mem_add_o, mem_valid_o, mem_data_o, err_o
  );

endinterface

// File: rtl/cache_block_transfer_buffer_block_word_buffer.sv
// One-block word store shared by writeback and fill: a single write port and
// an asynchronous read port so the head word is visible without a read cycle.
module block_word_buffer
  import cache_block_transfer_buffer_pkg::*;
#(
  parameter int BW_BLOCK = BW_BLOCK_DEF
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [BW_BLOCK-1:0] i_widx,
  input  logic [31:0]         i_wdata,
  input  logic [BW_BLOCK-1:0] i_ridx,
  output logic [31:0]         o_rdata
);

  logic [31:0] r_mem [words_per_block(BW_BLOCK)];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/cache_block_transfer_buffer.sv
// Converts the cache's block request / word push / word pop handshake into a
// single-request, burst-data memory protocol, buffering one block at a time.
module cache_block_transfer_buffer
  import cache_block_transfer_buffer_pkg::*;
#(
  parameter int BW_ADDR  = 24,
  parameter int BW_BLOCK = BW_BLOCK_DEF
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  cache_block_transfer_buffer_if.slave  bus
);

  localparam int                 N         = words_per_block(BW_BLOCK);
  localparam int                 CW        = BW_BLOCK + 1;
  localparam logic [CW-1:0]      N_CNT     = CW'(N);
  localparam logic [CW-1:0]      LAST_CNT  = CW'(N - 1);
  localparam logic [BW_ADDR-1:0] ADDR_MASK = ~BW_ADDR'(N - 1);

  state_t             r_state;
  logic [CW-1:0]      r_wcnt;
  logic [CW-1:0]      r_rcnt;
  logic [BW_ADDR-1:0] r_addr;
  logic               r_rw;
  logic               r_err;

  logic        w_ready_write;
  logic        w_ready_read;
  logic        w_push;
  logic        w_fill;
  logic        w_pop;
  logic        w_we;
  logic        w_err_evt;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;

  assign w_ready_write = (r_state == ST_WB_FILL) && (r_wcnt < N_CNT);
  assign w_ready_read  = (r_state == ST_RD_FILL) && (r_rcnt < r_wcnt);
  assign w_push        = bus.cache_write_i && w_ready_write;
  assign w_fill        = bus.mem_valid_i && (r_state == ST_RD_FILL) && (r_wcnt < N_CNT);
  assign w_pop         = bus.cache_read_i && w_ready_read;
  assign w_we          = w_push || w_fill;
  assign w_wdata       = (r_state == ST_WB_FILL) ? bus.cache_data_i : bus.mem_data_i;

  // Any rejected handshake is flagged; the gated strobes above keep it harmless.
  assign w_err_evt = (bus.cache_write_i && !w_ready_write)
                  || (bus.cache_read_i && !w_ready_read)
                  || (bus.cache_req_i && (r_state != ST_IDLE))
                  || (bus.mem_valid_i && !w_fill);

  block_word_buffer #(
    .BW_BLOCK (BW_BLOCK)
  ) u_buf (
    .i_clk   (clock_i),
    .i_we    (w_we),
    .i_widx  (r_wcnt[BW_BLOCK-1:0]),
    .i_wdata (w_wdata),
    .i_ridx  (r_rcnt[BW_BLOCK-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus.cache_ready_req_o   = (r_state == ST_IDLE);
  assign bus.cache_ready_write_o = w_ready_write;
  assign bus.cache_ready_read_o  = w_ready_read;
  assign bus.cache_data_o        = w_rdata;
  assign bus.mem_req_o           = (r_state == ST_WB_ISSUE) || (r_state == ST_RD_ISSUE);
  assign bus.mem_rw_o            = r_rw;
  assign bus.mem_add_o           = r_addr;
  assign bus.mem_valid_o         = (r_state == ST_WB_SEND);
  assign bus.mem_data_o          = w_rdata;
  assign bus.err_o               = r_err;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_rcnt  <= '0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.cache_req_i) begin
            r_addr  <= bus.cache_add_i & ADDR_MASK;
            r_rw    <= bus.cache_rw_i;
            r_state <= bus.cache_rw_i ? ST_WB_FILL : ST_RD_ISSUE;
          end
        end
        ST_WB_FILL: begin
          if (w_push) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == LAST_CNT) begin
              r_state <= ST_WB_ISSUE;
            end
          end
        end
        ST_WB_ISSUE: begin
          if (bus.mem_ready_i) begin
            r_state <= ST_WB_SEND;
          end
        end
        ST_WB_SEND: begin
          // The read counter doubles as the send index; memory never stalls.
          if (r_rcnt == LAST_CNT) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        ST_RD_ISSUE: begin
          if (bus.mem_ready_i) begin
            r_state <= ST_RD_FILL;
          end
        end
        ST_RD_FILL: begin
          if (w_fill) begin
            r_wcnt <= r_wcnt + 1'b1;
          end
          if (w_pop) begin
            if (r_rcnt == LAST_CNT) begin
              r_state <= ST_IDLE;
              r_wcnt  <= '0;
              r_rcnt  <= '0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_wcnt  <= '0;
          r_rcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_block_transfer_buffer.sv
// Bench for the block-transfer buffer: table of directed transfers, hand-built
// corner sequences, then random transfers checked against a queue-based model.
module tb_cache_block_transfer_buffer;

  localparam int N = 4;

  typedef struct {
    bit          rw;
    logic [23:0] addr;
    logic [31:0] base;
    int          dly;
    int          gmin;
    int          gmax;
    int          pprob;
    bit          hold;
    logic [23:0] exp_add;
  } vec_t;

  logic        clk;
  logic        rst;
  int          n_checks;
  int          n_fail;
  int          txn_no;
  bit          exp_err;
  logic [31:0] cur_w [N];
  vec_t        vecs [5];

  cache_block_transfer_buffer_if #(.BW_ADDR(24)) bus ();

  cache_block_transfer_buffer #(
    .BW_ADDR  (24),
    .BW_BLOCK (2)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=time limit reached required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.cache_req_i   = 1'b0;
    bus.cache_rw_i    = 1'b0;
    bus.cache_add_i   = '0;
    bus.cache_write_i = 1'b0;
    bus.cache_data_i  = '0;
    bus.cache_read_i  = 1'b0;
    bus.mem_ready_i   = 1'b0;
    bus.mem_valid_i   = 1'b0;
    bus.mem_data_i    = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready_req"},   32'(bus.cache_ready_req_o),   32'd1);
    chk({tag, "_ready_write"}, 32'(bus.cache_ready_write_o), 32'd0);
    chk({tag, "_ready_read"},  32'(bus.cache_ready_read_o),  32'd0);
    chk({tag, "_mem_req"},     32'(bus.mem_req_o),           32'd0);
    chk({tag, "_mem_valid"},   32'(bus.mem_valid_o),         32'd0);
    chk({tag, "_mem_rw"},      32'(bus.mem_rw_o),            32'd0);
    chk({tag, "_mem_add"},     32'(bus.mem_add_o),           32'd0);
    chk({tag, "_err"},         32'(bus.err_o),               32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_err = 1'b0;
    tick();
  endtask

  // Writeback: push cur_w, wait dly cycles of mem_req, then expect the burst.
  task automatic do_writeback(input logic [23:0] addr, input int dly, input int gmin,
                              input int gmax, input bit extra, input int abort_at,
                              input logic [23:0] exp_add);
    txn_no++;
    chk("wb_ready_req", 32'(bus.cache_ready_req_o), 32'd1);
    bus.cache_req_i = 1'b1;
    bus.cache_rw_i  = 1'b1;
    bus.cache_add_i = addr;
    tick();
    bus.cache_req_i = 1'b0;
    chk("wb_busy", 32'(bus.cache_ready_req_o), 32'd0);
    for (int i = 0; i < N; i++) begin
      int gap;
      gap = $urandom_range(gmax, gmin);
      for (int g = 0; g < gap; g++) begin
        chk("wb_gap_req", 32'(bus.mem_req_o), 32'd0);
        tick();
      end
      chk("wb_ready_write", 32'(bus.cache_ready_write_o), 32'd1);
      bus.cache_write_i = 1'b1;
      bus.cache_data_i  = cur_w[i];
      tick();
      bus.cache_write_i = 1'b0;
    end
    chk("wb_mem_req", 32'(bus.mem_req_o), 32'd1);
    chk("wb_mem_rw", 32'(bus.mem_rw_o), 32'd1);
    chk("wb_mem_add", 32'(bus.mem_add_o), 32'(exp_add));
    chk("wb_issue_no_write", 32'(bus.cache_ready_write_o), 32'd0);
    if (extra) begin
      bus.cache_write_i = 1'b1;
      bus.cache_data_i  = 32'hDEADBEEF;
      tick();
      bus.cache_write_i = 1'b0;
      exp_err = 1'b1;
      chk("wb_extra_err", 32'(bus.err_o), 32'd1);
      chk("wb_extra_req", 32'(bus.mem_req_o), 32'd1);
    end
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("wb_req_hold", 32'(bus.mem_req_o), 32'd1);
    end
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        #3 rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        #1 rst = 1'b0;
        exp_err = 1'b0;
        tick();
        $display("txn %0d: writeback addr=%06h aborted by reset after %0d words", txn_no, addr, i);
        return;
      end
      chk("wb_valid", 32'(bus.mem_valid_o), 32'd1);
      chk("wb_data", bus.mem_data_o, cur_w[i]);
      chk("wb_send_no_req", 32'(bus.mem_req_o), 32'd0);
      tick();
    end
    chk("wb_done_valid", 32'(bus.mem_valid_o), 32'd0);
    chk("wb_done_ready_req", 32'(bus.cache_ready_req_o), 32'd1);
    chk("wb_done_err", 32'(bus.err_o), 32'(exp_err));
    $display("txn %0d: writeback addr=%06h mem_add=%06h words=%0d", txn_no, addr, exp_add, N);
  endtask

  // Fill: memory supplies cur_w with random/fixed gaps; the cache pops per pprob.
  // Model: words enter a queue the cycle after mem_valid; the queue head is what
  // the cache must see, and readiness is simply "queue not empty".
  task automatic do_fill(input logic [23:0] addr, input int dly, input int gmin,
                         input int gmax, input int pprob, input bit hold,
                         input logic [23:0] exp_add);
    logic [31:0] q[$];
    int          sent;
    int          popped;
    int          wait_cnt;
    int          guard;
    bit          v;
    bit          p;
    txn_no++;
    chk("fill_ready_req", 32'(bus.cache_ready_req_o), 32'd1);
    bus.cache_req_i = 1'b1;
    bus.cache_rw_i  = 1'b0;
    bus.cache_add_i = addr;
    tick();
    bus.cache_req_i = 1'b0;
    chk("fill_mem_req", 32'(bus.mem_req_o), 32'd1);
    chk("fill_mem_rw", 32'(bus.mem_rw_o), 32'd0);
    chk("fill_mem_add", 32'(bus.mem_add_o), 32'(exp_add));
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("fill_req_hold", 32'(bus.mem_req_o), 32'd1);
    end
    bus.mem_ready_i = 1'b1;
    tick();
    bus.mem_ready_i = 1'b0;
    chk("fill_req_drop", 32'(bus.mem_req_o), 32'd0);
    sent     = 0;
    popped   = 0;
    guard    = 0;
    wait_cnt = $urandom_range(gmax, gmin);
    while (popped < N && guard < 300) begin
      chk("fill_ready_read", 32'(bus.cache_ready_read_o), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("fill_data", bus.cache_data_o, q[0]);
      end
      v = (sent < N) && (wait_cnt == 0);
      p = (q.size() > 0) && (!hold || sent == N) && ($urandom_range(100, 1) <= pprob);
      bus.mem_valid_i  = v;
      bus.mem_data_i   = v ? cur_w[sent] : $urandom;
      bus.cache_read_i = p;
      tick();
      bus.mem_valid_i  = 1'b0;
      bus.cache_read_i = 1'b0;
      if (p) begin
        void'(q.pop_front());
        popped++;
      end
      if (v) begin
        q.push_back(cur_w[sent]);
        sent++;
        wait_cnt = $urandom_range(gmax, gmin);
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
      guard++;
    end
    if (guard >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL fill_timeout: actual=%0d pops required=%0d", popped, N);
    end
    chk("fill_done_ready_req", 32'(bus.cache_ready_req_o), 32'd1);
    chk("fill_done_ready_read", 32'(bus.cache_ready_read_o), 32'd0);
    chk("fill_done_err", 32'(bus.err_o), 32'(exp_err));
    $display("txn %0d: fill addr=%06h mem_add=%06h words=%0d", txn_no, addr, exp_add, N);
  endtask

  task automatic run_vec(input vec_t vv);
    for (int i = 0; i < N; i++) cur_w[i] = vv.base + 32'(i);
    if (vv.rw) do_writeback(vv.addr, vv.dly, vv.gmin, vv.gmax, 1'b0, -1, vv.exp_add);
    else       do_fill(vv.addr, vv.dly, vv.gmin, vv.gmax, vv.pprob, vv.hold, vv.exp_add);
  endtask

  initial begin
    //           rw    addr          base          dly gmin gmax pprob hold  exp_add
    vecs[0] = '{1'b1, 24'h000123, 32'h000000A0, 3,  0,   0,   100,  1'b0, 24'h000120};
    vecs[1] = '{1'b0, 24'h000045, 32'h000000B0, 1,  2,   2,   100,  1'b0, 24'h000044};
    vecs[2] = '{1'b0, 24'h000045, 32'h000000B0, 0,  0,   0,   100,  1'b1, 24'h000044};
    vecs[3] = '{1'b1, 24'hFFFFFF, 32'h00000055, 0,  1,   2,   100,  1'b0, 24'hFFFFFC};
    vecs[4] = '{1'b0, 24'h000003, 32'h000000C0, 2,  0,   0,   50,   1'b0, 24'h000000};

    n_checks = 0;
    n_fail   = 0;
    txn_no   = 0;
    exp_err  = 1'b0;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("reset");
    tick();

    // Pop in IDLE: flagged, nothing else moves.
    bus.cache_read_i = 1'b1;
    tick();
    bus.cache_read_i = 1'b0;
    exp_err = 1'b1;
    chk("idle_read_err", 32'(bus.err_o), 32'd1);
    chk("idle_read_state", 32'(bus.cache_ready_req_o), 32'd1);
    chk("idle_read_no_req", 32'(bus.mem_req_o), 32'd0);
    $display("txn probe: cache_read_i in IDLE");

    foreach (vecs[k]) run_vec(vecs[k]);

    // Fill word arriving while IDLE.
    pulse_reset();
    chk("memv_pre_err", 32'(bus.err_o), 32'd0);
    bus.mem_valid_i = 1'b1;
    tick();
    bus.mem_valid_i = 1'b0;
    chk("memv_idle_err", 32'(bus.err_o), 32'd1);
    chk("memv_idle_state", 32'(bus.cache_ready_req_o), 32'd1);
    $display("txn probe: mem_valid_i in IDLE");

    // Second request while the first is still issuing.
    pulse_reset();
    bus.cache_req_i = 1'b1;
    bus.cache_rw_i  = 1'b0;
    bus.cache_add_i = 24'h000010;
    tick();
    bus.cache_add_i = 24'h000777;
    bus.cache_rw_i  = 1'b1;
    tick();
    bus.cache_req_i = 1'b0;
    chk("req_busy_err", 32'(bus.err_o), 32'd1);
    chk("req_busy_add", 32'(bus.mem_add_o), 32'h000010);
    chk("req_busy_rw", 32'(bus.mem_rw_o), 32'd0);
    $display("txn probe: cache_req_i outside IDLE");

    // Fifth push after a full block: ignored, block still sent intact.
    pulse_reset();
    for (int i = 0; i < N; i++) cur_w[i] = 32'h5000_0000 + 32'(i * 7);
    do_writeback(24'h000456, 1, 0, 0, 1'b1, -1, 24'h000454);

    // Reset during the burst after two words, then a normal fill.
    for (int i = 0; i < N; i++) cur_w[i] = 32'hAB00_0000 + 32'(i);
    do_writeback(24'h00ABCD, 0, 0, 0, 1'b0, 2, 24'h00ABCC);
    for (int i = 0; i < N; i++) cur_w[i] = 32'h0000_00B0 + 32'(i);
    do_fill(24'h000045, 1, 1, 1, 100, 1'b0, 24'h000044);

    // Writeback immediately followed by a fill request.
    for (int i = 0; i < N; i++) cur_w[i] = 32'hCAFE_0000 + 32'(i);
    do_writeback(24'h000200, 0, 0, 0, 1'b0, -1, 24'h000200);
    for (int i = 0; i < N; i++) cur_w[i] = 32'hF00D_0000 + 32'(i);
    do_fill(24'h000301, 0, 0, 0, 100, 1'b0, 24'h000300);

    for (int t = 0; t < 12; t++) begin
      logic [23:0] a;
      a = 24'($urandom);
      for (int i = 0; i < N; i++) cur_w[i] = $urandom;
      if ($urandom_range(1, 0) == 1)
        do_writeback(a, $urandom_range(4, 0), 0, $urandom_range(3, 0), 1'b0, -1, a & 24'hFFFFFC);
      else
        do_fill(a, $urandom_range(4, 0), 0, $urandom_range(3, 0), $urandom_range(100, 30),
                1'($urandom_range(1, 0)), a & 24'hFFFFFC);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
